// File: rtl/instr_cache.sv
// rtl/instr_cache.sv - Direct-mapped read-only instruction cache with a single-line burst refill FSM.
module instr_cache #(
    parameter int DATA_WIDTH     = 32,
    parameter int LINES          = 64,
    parameter int WORDS_PER_LINE = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] fetch_addr,
    input  logic                  fetch_req,
    input  logic                  invalidate_all,
    output logic [DATA_WIDTH-1:0] instr_out,
    output logic                  instr_valid,
    output logic                  busy,
    output logic                  mem_req,
    output logic [DATA_WIDTH-1:0] mem_addr,
    input  logic                  mem_ack,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_rvalid
);

    localparam int WSEL = $clog2(WORDS_PER_LINE);
    localparam int OFF  = WSEL + 2;
    localparam int IDX  = $clog2(LINES);
    localparam int TAGW = DATA_WIDTH - OFF - IDX;
    localparam int LINEW = DATA_WIDTH - OFF;
    localparam logic [DATA_WIDTH-1:0] NOP = DATA_WIDTH'(32'h0000_0013);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_FILL} state_t;

    state_t                 state_q, state_d;
    logic [LINES-1:0]       valid_q, valid_d;
    logic [TAGW-1:0]        tag_q [LINES];
    logic [DATA_WIDTH-1:0]  data_q [LINES*WORDS_PER_LINE];
    logic [LINEW-1:0]       miss_line_q, miss_line_d;
    logic                   mem_req_q, mem_req_d;
    logic [WSEL-1:0]        cnt_q, cnt_d;
    logic                   kill_q, kill_d;
    logic                   data_we, line_we;

    logic [WSEL-1:0] f_word;
    logic [IDX-1:0]  f_idx, m_idx;
    logic [TAGW-1:0] f_tag, m_tag;
    logic            hit;
    logic [1:0]      unused_addr_bits;

    assign f_word = fetch_addr[OFF-1:2];
    assign f_idx  = fetch_addr[OFF+IDX-1:OFF];
    assign f_tag  = fetch_addr[DATA_WIDTH-1:OFF+IDX];
    assign m_idx  = miss_line_q[IDX-1:0];
    assign m_tag  = miss_line_q[LINEW-1:IDX];
    assign unused_addr_bits = fetch_addr[1:0];

    assign hit         = fetch_req && (state_q == S_IDLE) && valid_q[f_idx] && (tag_q[f_idx] == f_tag);
    assign instr_valid = hit;
    assign instr_out   = hit ? data_q[{f_idx, f_word}] : NOP;
    assign busy        = (state_q != S_IDLE) || (fetch_req && !hit);
    assign mem_req     = mem_req_q;
    assign mem_addr    = {miss_line_q, {OFF{1'b0}}};

    always_comb begin
        state_d     = state_q;
        valid_d     = valid_q;
        miss_line_d = miss_line_q;
        mem_req_d   = mem_req_q;
        cnt_d       = cnt_q;
        kill_d      = kill_q;
        data_we     = 1'b0;
        line_we     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (invalidate_all) valid_d = '0;
                if (fetch_req && !hit) begin
                    miss_line_d = fetch_addr[DATA_WIDTH-1:OFF];
                    mem_req_d   = 1'b1;
                    state_d     = S_REQ;
                end
            end
            S_REQ: begin
                if (invalidate_all) begin
                    valid_d = '0;
                    kill_d  = 1'b1;
                end
                if (mem_ack) begin
                    mem_req_d = 1'b0;
                    cnt_d     = '0;
                    state_d   = S_FILL;
                end
            end
            S_FILL: begin
                if (invalidate_all) begin
                    valid_d = '0;
                    kill_d  = 1'b1;
                end
                if (mem_rvalid) begin
                    data_we = 1'b1;
                    cnt_d   = cnt_q + 1'b1;
                    if (cnt_q == WSEL'(WORDS_PER_LINE - 1)) begin
                        // A fence.i seen at any point of this refill leaves the line invalid.
                        kill_d  = 1'b0;
                        state_d = S_IDLE;
                        if (!kill_q && !invalidate_all) begin
                            valid_d[m_idx] = 1'b1;
                            line_we        = 1'b1;
                        end
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            valid_q     <= '0;
            miss_line_q <= '0;
            mem_req_q   <= 1'b0;
            cnt_q       <= '0;
            kill_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            valid_q     <= valid_d;
            miss_line_q <= miss_line_d;
            mem_req_q   <= mem_req_d;
            cnt_q       <= cnt_d;
            kill_q      <= kill_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && data_we) data_q[{m_idx, cnt_q}] <= mem_rdata;
        if (!reset && line_we) tag_q[m_idx] <= m_tag;
    end

endmodule

// File: tb/tb_instr_cache.sv
// tb/tb_instr_cache.sv - Self-checking bench for instr_cache against a line-level reference model.
module tb_instr_cache;
    localparam int DW    = 32;
    localparam int LINES = 64;
    localparam int WPL   = 4;
    localparam int OFF   = 4;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [DW-1:0] fetch_addr = '0;
    logic          fetch_req = 1'b0;
    logic          invalidate_all = 1'b0;
    logic [DW-1:0] instr_out;
    logic          instr_valid;
    logic          busy;
    logic          mem_req;
    logic [DW-1:0] mem_addr;
    logic          mem_ack = 1'b0;
    logic [DW-1:0] mem_rdata = '0;
    logic          mem_rvalid = 1'b0;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: which full line address each index currently holds.
    bit          model_valid [LINES];
    logic [31:0] model_line  [LINES];

    instr_cache #(.DATA_WIDTH(DW), .LINES(LINES), .WORDS_PER_LINE(WPL)) dut (
        .clk(clk), .reset(reset), .fetch_addr(fetch_addr), .fetch_req(fetch_req),
        .invalidate_all(invalidate_all), .instr_out(instr_out), .instr_valid(instr_valid),
        .busy(busy), .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
        .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1);
    end

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'h13 + (a >> 2) * 32'h0010_0080;
    endfunction

    function automatic bit model_hit(input logic [31:0] a);
        int idx;
        idx = int'((a >> OFF) % LINES);
        return model_valid[idx] && (model_line[idx] == (a >> OFF));
    endfunction

    function automatic void model_clear();
        for (int i = 0; i < LINES; i++) model_valid[i] = 1'b0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One lookup; on a miss plays the memory side of the refill. Starts and ends at posedge+1.
    task automatic access(input logic [31:0] a, input int inv_beat, input bit redir, input logic [31:0] ra);
        bit          h;
        logic [31:0] base;
        int          n;
        int          idx;
        h    = model_hit(a);
        base = a & ~32'(WPL * 4 - 1);
        fetch_req  = 1'b1;
        fetch_addr = a;
        #1;
        chk("lookup_valid", {31'b0, instr_valid}, {31'b0, h});
        chk("lookup_busy", {31'b0, busy}, {31'b0, !h});
        chk("lookup_data", instr_out, h ? mem_word(a & ~32'h3) : NOP);
        tick();
        if (h) return;
        if (redir) fetch_addr = ra;
        n = $urandom_range(0, 2);
        for (int i = 0; i <= n; i++) begin
            #1;
            chk("req_mem_req", {31'b0, mem_req}, 32'd1);
            chk("req_mem_addr", mem_addr, base);
            chk("req_busy", {31'b0, busy}, 32'd1);
            if (i == n) mem_ack = 1'b1;
            tick();
        end
        mem_ack = 1'b0;
        #1;
        chk("req_drop", {31'b0, mem_req}, 32'd0);
        for (int b = 0; b < WPL; b++) begin
            repeat ($urandom_range(0, 1)) tick();
            mem_rvalid     = 1'b1;
            mem_rdata      = mem_word(base + 32'(4 * b));
            invalidate_all = (b == inv_beat);
            #1;
            chk("fill_busy", {31'b0, busy}, 32'd1);
            chk("fill_no_hit", {31'b0, instr_valid}, 32'd0);
            tick();
            mem_rvalid     = 1'b0;
            invalidate_all = 1'b0;
        end
        idx = int'((a >> OFF) % LINES);
        if (inv_beat >= 0) model_clear();
        else begin
            model_valid[idx] = 1'b1;
            model_line[idx]  = a >> OFF;
        end
        #1;
        chk("idle_mem_req", {31'b0, mem_req}, 32'd0);
    endtask

    initial begin
        model_clear();
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        chk("rst_valid", {31'b0, instr_valid}, 32'd0);
        chk("rst_out", instr_out, NOP);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_mem_req", {31'b0, mem_req}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);

        // First refill and same-line hits
        access(32'h0, -1, 1'b0, 32'h0);
        access(32'h0, -1, 1'b0, 32'h0);
        chk("first_word", instr_out, 32'h0000_0013);
        access(32'h8, -1, 1'b0, 32'h0);
        chk("word2", instr_out, 32'h0020_0113);

        // Conflict on index 0
        access(32'h400, -1, 1'b0, 32'h0);
        access(32'h400, -1, 1'b0, 32'h0);
        access(32'h0, -1, 1'b0, 32'h0);
        access(32'h0, -1, 1'b0, 32'h0);

        // No request: no lookup, no miss handling
        fetch_req  = 1'b0;
        fetch_addr = 32'h0;
        #1;
        chk("noreq_valid", {31'b0, instr_valid}, 32'd0);
        chk("noreq_busy", {31'b0, busy}, 32'd0);
        chk("noreq_out", instr_out, NOP);
        tick();
        #1;
        chk("noreq_mem_req", {31'b0, mem_req}, 32'd0);

        // Invalidate during beat 2, and on the final beat
        access(32'h10, -1, 1'b0, 32'h0);
        access(32'h30, 2, 1'b0, 32'h0);
        access(32'h30, -1, 1'b0, 32'h0);
        access(32'h10, -1, 1'b0, 32'h0);
        access(32'h0, -1, 1'b0, 32'h0);
        access(32'h40, 3, 1'b0, 32'h0);
        access(32'h40, -1, 1'b0, 32'h0);
        access(32'h40, -1, 1'b0, 32'h0);

        // Invalidate in IDLE: same-cycle lookup still hits
        fetch_req      = 1'b1;
        fetch_addr     = 32'h44;
        invalidate_all = 1'b1;
        #1;
        chk("inv_idle_hit", {31'b0, instr_valid}, 32'd1);
        chk("inv_idle_data", instr_out, mem_word(32'h44));
        tick();
        invalidate_all = 1'b0;
        model_clear();
        access(32'h40, -1, 1'b0, 32'h0);
        access(32'h0, -1, 1'b0, 32'h0);
        access(32'h0, -1, 1'b0, 32'h0);

        // Reset in the middle of a fill, then stray beats
        fetch_req  = 1'b1;
        fetch_addr = 32'h50;
        tick();
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        for (int b = 0; b < 2; b++) begin
            mem_rvalid = 1'b1;
            mem_rdata  = mem_word(32'h50 + 32'(4 * b));
            tick();
        end
        mem_rvalid = 1'b0;
        reset = 1'b1;
        tick();
        reset     = 1'b0;
        fetch_req = 1'b0;
        model_clear();
        for (int i = 0; i < 3; i++) begin
            mem_rvalid = 1'b1;
            mem_rdata  = 32'hdead_beef;
            #1;
            chk("stray_mem_req", {31'b0, mem_req}, 32'd0);
            chk("stray_busy", {31'b0, busy}, 32'd0);
            chk("stray_valid", {31'b0, instr_valid}, 32'd0);
            tick();
        end
        mem_rvalid = 1'b0;

        // Redirect during REQ: refill of 0x0 completes, then 0x20 misses
        access(32'h0, -1, 1'b1, 32'h20);
        access(32'h20, -1, 1'b0, 32'h0);
        access(32'h0, -1, 1'b0, 32'h0);
        access(32'h50, -1, 1'b0, 32'h0);

        // Randomized traffic over a few conflicting lines
        for (int k = 0; k < 40; k++) begin
            logic [31:0] a;
            int          inv;
            a = (32'($urandom_range(0, 2)) << 10) | (32'($urandom_range(0, 3)) << OFF)
              | (32'($urandom_range(0, 3)) << 2);
            inv = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 3)) : -1;
            if ($urandom_range(0, 3) == 0) begin
                fetch_req = 1'b0;
                tick();
            end
            access(a, inv, 1'b0, 32'h0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/instr_cache.md
Name: instr_cache

Overview:
- Direct-mapped, read-only instruction cache on the responder side of the fetch-stage instruction interface.
- The fetch stage presents a PC each cycle. This block returns the instruction word plus a valid flag in the same cycle on a hit.
- On a miss it raises a busy flag toward the hazard/stall logic and refills one line from the memory bus with a burst FSM.
- Sits between the fetch stage and the memory/bus arbiter.

Parameters:
- DATA_WIDTH, 32, instruction and address width.
- LINES, 64, number of cache lines (power of 2).
- WORDS_PER_LINE, 4, 32-bit words per line (power of 2, >=2).

Ports:
- clk  input  1  clock, all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- fetch_addr  input  DATA_WIDTH  PC from the fetch stage; bits [1:0] ignored.
- fetch_req  input  1  lookup request; low means no lookup and no miss handling.
- invalidate_all  input  1  one-cycle pulse (fence.i); clears every valid bit.
- instr_out  output  DATA_WIDTH  instruction word on a hit, NOP (0x00000013) otherwise.
- instr_valid  output  1  high when instr_out is a hit for fetch_addr.
- busy  output  1  miss in progress; the fetch stage must stall.
- mem_req  output  1  refill request to the memory bus.
- mem_addr  output  DATA_WIDTH  line-aligned refill base address.
- mem_ack  input  1  memory accepted the request (one-cycle pulse).
- mem_rdata  input  DATA_WIDTH  refill data beat.
- mem_rvalid  input  1  mem_rdata valid.

Behaviour:
- Address split: OFF = log2(WORDS_PER_LINE)+2 and IDX = log2(LINES).
  - word select = addr[OFF-1:2]
  - index = addr[OFF+IDX-1:OFF]
  - tag = addr[DATA_WIDTH-1:OFF+IDX]
- Storage is register arrays: valid[LINES], tag[LINES], data[LINES*WORDS_PER_LINE]. Reads are combinational.
- Hit = fetch_req & state==IDLE & valid[index] & tag match.
  - instr_valid = hit, with instr_out = data word, in the same cycle (zero latency).
  - Otherwise instr_valid=0 and instr_out=NOP.
- Reset values: all valid bits 0, state IDLE, instr_valid 0, instr_out NOP, busy 0, mem_req 0, mem_addr 0, beat counter 0.
- FSM states:
  - IDLE: a miss (fetch_req & ~hit) latches the miss address, sets mem_addr = fetch_addr with the low OFF bits cleared, and moves to REQ in the next cycle. busy is asserted combinationally in the miss cycle and stays high until return to IDLE.
  - REQ: mem_req=1, held until mem_ack=1. On mem_ack the next state is FILL, mem_req drops the following cycle, and the counter is cleared.
  - FILL: each mem_rvalid beat writes data[latched index][counter] and increments the counter. Beats arrive in ascending word order starting at word 0. On the beat where counter==WORDS_PER_LINE-1:
    - valid[index] is set and tag[index] is written, unless the kill flag is set;
    - the kill flag is cleared;
    - the state returns to IDLE.
- After the refill, the first IDLE cycle re-evaluates fetch_addr normally: hit if unchanged.
- A fetch_addr change during REQ/FILL (branch or exception redirect) does not abort the refill. The latched address is used. Any new miss is handled after return to IDLE.
- mem_rvalid outside FILL is ignored.
- invalidate_all:
  - In IDLE: clears all valid bits at the next edge. A lookup in the same cycle still uses the pre-clear bits.
  - In REQ/FILL: clears all valid bits and sets a kill flag, so the in-flight line completes the FSM but is not marked valid.
- invalidate_all and the final refill beat in the same cycle: the line is not marked valid.
- reset mid-refill: immediately to IDLE at that edge; mem_req 0; all valid bits cleared; the kill flag is cleared; later stray beats are ignored.
- fetch_req=0 in IDLE: no state change, instr_valid=0, busy=0.

Test Plan:
- Reset, fetch_req=1, fetch_addr=0x0000_0000 -> busy=1 and instr_valid=0 in the same cycle. Next cycle mem_req=1 and mem_addr=0x0. After ack plus 4 beats (0x13,0x00100093,0x00200113,0x00300193), in the first IDLE cycle instr_valid=1 and instr_out=0x13.
- Same line, fetch_addr=0x8 -> instr_valid=1, instr_out=0x00200113 in the same cycle, no mem_req.
- Conflict: fetch_addr=0x400 (same index, different tag) -> miss, refill from mem_addr=0x400. Then 0x0 misses again.
- invalidate_all pulsed during beat 2 of a refill -> after completion the same address still misses (new mem_req). All previously valid lines miss.
- reset asserted mid-FILL, then stray mem_rvalid beats -> state IDLE, mem_req=0, busy=0. No line becomes valid, so the first lookup at 0x0 misses.
- fetch_addr changed from 0x0 to 0x20 during REQ -> refill completes for line 0x0. Then 0x20 misses with mem_addr=0x20, and 0x0 hits afterwards.
